uart_cmd_sender: RTL and testbench
==================================

UART_CMD_SENDER -- requirements
Module: uart_cmd_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2604, clock cycles per UART bit period (minimum 4).
REQ-002 clk  input  1  system clock; all logic rising-edge triggered.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 snd_cmd  input  1  request to transmit cmd; sampled on rising edge of clk.
REQ-005 cmd  input  24  command word to transmit.
REQ-006 TX  output  1  serial output, 8N1, idle high.
REQ-007 busy  output  1  high while a command is being transmitted.
REQ-008 cmd_sent  output  1  one-cycle pulse when all three frames are complete.
REQ-009 RX  input  1  serial input carrying the response byte, 8N1; asynchronous to clk.
REQ-010 resp  output  8  last correctly framed response byte.
REQ-011 resp_rdy  output  1  high when resp holds an unread byte.
REQ-012 clr_resp_rdy  input  1  clears resp_rdy.

Function
REQ-013 Transmit FSM states SHALL be IDLE and SHIFT; a byte counter (0..2) and a bit counter (0..9) SHALL track position, and a baud counter (0..CLKS_PER_BIT-1) SHALL time each bit.
REQ-014 IDLE with snd_cmd=1 SHALL latch cmd, go to SHIFT, and set busy=1; TX SHALL drive the start bit (0) from the next cycle.
REQ-015 Bytes SHALL be sent cmd[23:16], cmd[15:8], cmd[7:0], in that order and back-to-back with no idle gap.
REQ-016 Each byte SHALL be sent as start 0, then data LSB first, then stop 1; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-017 After the third stop bit completes (30*CLKS_PER_BIT cycles after TX first goes low), the block SHALL return to IDLE, set busy=0, and pulse cmd_sent for one cycle, all on the same cycle.
REQ-018 snd_cmd while busy=1 SHALL be ignored, and the latched command SHALL NOT change.
REQ-019 snd_cmd on the same cycle that cmd_sent is pulsed SHALL be accepted.
REQ-020 RX SHALL be double-flop synchronized before use.
REQ-021 The receive FSM SHALL have the states IDLE, START, DATA and STOP, and SHALL run independently of the transmit FSM.
REQ-022 In receive IDLE, a synchronized falling edge on RX SHALL enter START.
REQ-023 In START, RX SHALL be sampled at CLKS_PER_BIT/2; if RX=1 the FSM SHALL return to IDLE as a false start.
REQ-024 In DATA, 8 bits SHALL be sampled at mid-bit, spaced CLKS_PER_BIT apart, and shifted in LSB first.
REQ-025 In STOP, RX SHALL be sampled at mid-bit; if RX=1, resp SHALL be loaded and resp_rdy set the next cycle, and if RX=0 (framing error) the byte SHALL be discarded with resp and resp_rdy unchanged; the FSM SHALL return to IDLE in both cases.
REQ-026 resp_rdy SHALL clear on clr_resp_rdy=1 or when snd_cmd is accepted.
REQ-027 If a resp_rdy set and a clear occur on the same cycle, the set SHALL win.
REQ-028 TX SHALL be driven from a flop, with no combinational glitches.

Reset
REQ-029 When rst=1, the block SHALL force TX=1, busy=0, cmd_sent=0, resp=8'h00 and resp_rdy=0, and put both FSMs in IDLE with all counters at 0, without waiting for a clock edge.
REQ-030 rst mid-frame SHALL abort the transfer with no partial resumption; the first snd_cmd after rst falls SHALL transmit a complete, correct 3-byte sequence.

Verification (CLKS_PER_BIT=16)
REQ-031 cmd=24'hCA7B67, one-cycle snd_cmd -> TX low one cycle later for 16 cycles; data bits for 0xCA SHALL be 0,1,0,1,0,0,1,1, then stop; 0x7B and 0x67 follow; cmd_sent pulses 480 cycles after TX first falls, with busy=0 on that cycle.
REQ-032 RX looped back to TX, cmd=24'hCA7B67 -> resp_rdy sets three times (clr_resp_rdy pulsed after each), resp = 8'hCA, 8'h7B, then 8'h67.
REQ-033 snd_cmd with cmd=24'h123456 pulsed at cycle 100 of a transfer of 24'hCA7B67 -> TX sequence SHALL be unchanged from REQ-031 and exactly one cmd_sent pulse SHALL occur.
REQ-034 RX driven with byte 8'hA5 and stop bit 0 -> resp_rdy stays 0 and resp stays 8'h00; a following good 8'h3C frame -> resp=8'h3C, resp_rdy=1.
REQ-035 rst asserted at cycle 200 of a transfer -> TX=1 and busy=0 immediately; after release, a new snd_cmd with 24'hCA7B67 SHALL produce the REQ-031 waveform exactly.
REQ-036 clr_resp_rdy=1 on the same cycle a good frame completes -> resp_rdy=1.

Source files
------------

// File: rtl/uart_cmd_sender.sv
// Sends a latched 24-bit command as three back-to-back 8N1 UART frames (MSB byte first)
// and independently receives 8N1 response bytes on RX.
module uart_cmd_sender #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [23:0] cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------- transmit
  tx_state_t       tx_state;
  logic [23:0]     cmd_reg;
  logic [1:0]      byte_cnt;
  logic [3:0]      bit_cnt;
  logic [BW-1:0]   tx_baud;
  logic [7:0]      cur_byte;
  logic            tx_accept;

  assign tx_accept = (tx_state == TX_IDLE) && snd_cmd;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cur_byte = cmd_reg[23:16];
    case (byte_cnt)
      2'd1:    cur_byte = cmd_reg[15:8];
      2'd2:    cur_byte = cmd_reg[7:0];
      default: cur_byte = cmd_reg[23:16];
    endcase
  end

  // TX always holds the level of the bit being sent; the next level is loaded as a bit ends.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      cmd_reg  <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      tx_baud  <= '0;
      TX       <= 1'b1;
      busy     <= 1'b0;
      cmd_sent <= 1'b0;
    end else begin
      cmd_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (snd_cmd) begin
            cmd_reg  <= cmd;
            tx_state <= TX_SHIFT;
            busy     <= 1'b1;
            TX       <= 1'b0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tx_baud  <= '0;
          end
        end
        TX_SHIFT: begin
          if (tx_baud == BAUD_MAX) begin
            tx_baud <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (byte_cnt == 2'd2) begin
                byte_cnt <= '0;
                tx_state <= TX_IDLE;
                busy     <= 1'b0;
                cmd_sent <= 1'b1;
                TX       <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                TX       <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              TX      <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
            end
          end else begin
            tx_baud <= tx_baud + BW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  rx_state_t       rx_state;
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  logic [BW-1:0]   rx_baud;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      if (clr_resp_rdy || tx_accept) resp_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_baud <= '0;
          rx_bit  <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_baud == BAUD_HALF) begin
            rx_baud  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_baud == BAUD_MAX) begin
            rx_baud  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_baud == BAUD_MAX) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
            // Placed after the clear above so a simultaneous set takes priority.
            if (rx_sync) begin
              resp     <= rx_shift;
              resp_rdy <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + BW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Directed bench for uart_cmd_sender at CLKS_PER_BIT=16: TX waveform, busy handling,
// loopback reception, framing errors, resp_rdy priority and mid-frame reset.
module tb_uart_cmd_sender;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [23:0] cmd;
  logic        tx;
  logic        busy;
  logic        cmd_sent;
  logic        rx_line;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;
  logic        rx_drv;
  logic        loop;

  int vectors = 0;
  int miscompares = 0;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cmd_sender #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .snd_cmd      (snd_cmd),
    .cmd          (cmd),
    .TX           (tx),
    .busy         (busy),
    .cmd_sent     (cmd_sent),
    .RX           (rx_line),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected TX level for bit slot idx (0..29) of a 3-frame command.
  function automatic logic exp_bit(input logic [23:0] c, input int idx);
    int k;
    int p;
    logic [7:0] b;
    k = idx / 10;
    p = idx % 10;
    b = c[23 - 8*k -: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic start_cmd(input logic [23:0] c, input string name);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_tx: tx=%b want 1", name, tx);
    end
    cmd = c;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
  endtask

  // Called right after start_cmd; ends on the cycle cmd_sent should be visible.
  task automatic check_frames(input logic [23:0] c, input int inject_at, input string name);
    for (int b = 0; b < 30; b++) begin
      logic err;
      logic a_tx, a_busy, a_sent;
      err = 1'b0;
      a_tx = 1'b0; a_busy = 1'b0; a_sent = 1'b0;
      for (int cyc = 0; cyc < CPB; cyc++) begin
        if (b*CPB + cyc == inject_at) begin
          cmd = 24'h123456;
          snd_cmd = 1'b1;
        end
        if (!err && (tx !== exp_bit(c, b) || busy !== 1'b1 || cmd_sent !== 1'b0)) begin
          err = 1'b1;
          a_tx = tx; a_busy = busy; a_sent = cmd_sent;
        end
        tick();
        snd_cmd = 1'b0;
      end
      vectors++;
      if (err) begin
        miscompares++;
        $display("FAIL %s bit%0d: tx=%b busy=%b cmd_sent=%b want tx=%b busy=1 cmd_sent=0",
                 name, b, a_tx, a_busy, a_sent, exp_bit(c, b));
      end
    end
    vectors++;
    if (cmd_sent !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: cmd_sent=%b busy=%b tx=%b want 1 0 1", name, cmd_sent, busy, tx);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (CPB) tick();
    end
    rx_drv = stop;
    repeat (CPB) tick();
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors += 5;
    if (tx !== 1'b1)       begin miscompares++; $display("FAIL reset tx: %b want 1", tx); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset busy: %b want 0", busy); end
    if (cmd_sent !== 1'b0) begin miscompares++; $display("FAIL reset cmd_sent: %b want 0", cmd_sent); end
    if (resp !== 8'h00)    begin miscompares++; $display("FAIL reset resp: %h want 00", resp); end
    if (resp_rdy !== 1'b0) begin miscompares++; $display("FAIL reset resp_rdy: %b want 0", resp_rdy); end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_tx_waveform();
    start_cmd(24'hCA7B67, "tx_ca7b67");
    check_frames(24'hCA7B67, -1, "tx_ca7b67");
    tick();
    vectors++;
    if (cmd_sent !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_pulse_width: cmd_sent=%b busy=%b want 0 0", cmd_sent, busy);
    end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    start_cmd(24'h00FF81, "b2b_first");
    check_frames(24'h00FF81, -1, "b2b_first");
    start_cmd(24'h5A0F3C, "b2b_second");
    check_frames(24'h5A0F3C, -1, "b2b_second");
    repeat (5) tick();
  endtask

  task automatic test_busy_ignore();
    logic err;
    start_cmd(24'hCA7B67, "busy_ign");
    check_frames(24'hCA7B67, 100, "busy_ign");
    tick();
    err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_sent !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) err = 1'b1;
      tick();
    end
    vectors++;
    if (err) begin
      miscompares++;
      $display("FAIL busy_ign_extra: extra activity after cmd_sent, want idle");
    end
    cmd = 24'h000000;
  endtask

  task automatic test_loopback();
    logic [7:0] got [3];
    logic [7:0] want [3];
    int n;
    want[0] = 8'hCA; want[1] = 8'h7B; want[2] = 8'h67;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    n = 0;
    loop = 1'b1;
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    start_cmd(24'hCA7B67, "loopback");
    for (int c = 0; c < 600; c++) begin
      if (resp_rdy === 1'b1) begin
        if (n < 3) got[n] = resp;
        n++;
        clr_resp_rdy = 1'b1;
      end
      tick();
      clr_resp_rdy = 1'b0;
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL loopback_count: %0d bytes want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL loopback_byte%0d: resp=%h want %h", i, got[i], want[i]);
      end
    end
    loop = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_framing_error();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    send_rx(8'hA5, 1'b0);
    repeat (6) tick();
    vectors += 2;
    if (resp_rdy !== 1'b0) begin miscompares++; $display("FAIL frame_err rdy: %b want 0", resp_rdy); end
    if (resp !== 8'h00)    begin miscompares++; $display("FAIL frame_err resp: %h want 00", resp); end
    send_rx(8'h3C, 1'b1);
    repeat (6) tick();
    vectors += 2;
    if (resp_rdy !== 1'b1) begin miscompares++; $display("FAIL good_3c rdy: %b want 1", resp_rdy); end
    if (resp !== 8'h3C)    begin miscompares++; $display("FAIL good_3c resp: %h want 3c", resp); end
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    vectors++;
    if (resp_rdy !== 1'b0) begin miscompares++; $display("FAIL clr_rdy: %b want 0", resp_rdy); end
    vectors++;
    if (resp !== 8'h3C) begin miscompares++; $display("FAIL clr_keeps_resp: %h want 3c", resp); end
  endtask

  // With clr held high through a whole frame, resp_rdy can only rise if set beats clear.
  task automatic test_clr_collision();
    logic seen;
    seen = 1'b0;
    clr_resp_rdy = 1'b1;
    tick();
    fork
      send_rx(8'h81, 1'b1);
      begin
        for (int c = 0; c < 10*CPB + 20; c++) begin
          tick();
          if (resp_rdy === 1'b1) seen = 1'b1;
        end
      end
    join
    clr_resp_rdy = 1'b0;
    vectors += 2;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL collision_rdy: rdy never 1, want set to win"); end
    if (resp !== 8'h81) begin miscompares++; $display("FAIL collision_resp: %h want 81", resp); end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_frame();
    start_cmd(24'hCA7B67, "rst_mid");
    repeat (199) tick();
    rst = 1'b1;
    #1;
    vectors += 3;
    if (tx !== 1'b1)        begin miscompares++; $display("FAIL rst_mid tx: %b want 1", tx); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_mid busy: %b want 0", busy); end
    if (resp_rdy !== 1'b0)  begin miscompares++; $display("FAIL rst_mid resp_rdy: %b want 0", resp_rdy); end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    start_cmd(24'hCA7B67, "after_rst");
    check_frames(24'hCA7B67, -1, "after_rst");
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    snd_cmd = 1'b0;
    cmd = '0;
    rx_drv = 1'b1;
    loop = 1'b0;
    clr_resp_rdy = 1'b0;
    test_reset();
    test_tx_waveform();
    test_back_to_back();
    test_busy_ignore();
    test_loopback();
    test_framing_error();
    test_clr_collision();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
